seq_nr_divider: RTL and testbench

Multi-cycle, parametrised non-restoring integer divider for the datapath's DIV instruction. It resolves one quotient bit per clock and handles signed or unsigned operands, selected per operation. It reports divide-by-zero and uses a start/busy/done handshake, so the control unit can stall on it.

---
 rtl/seq_nr_divider_if.sv | 39 +++
 rtl/seq_nr_divider.sv | 171 +++++++++++++++++
 tb/tb_seq_nr_divider.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_nr_divider_if.sv
// ---------------------------------------------------------------------------
// seq_nr_divider_if
//   Request/result bundle for the sequential non-restoring divider.
//   master : the control unit side (drives the request, reads the results)
//   slave  : the divider side
//
//   start        request a divide (sampled only while busy=0)
//   is_signed    1 = two's-complement operands, 0 = unsigned
//   dividend     numerator, WIDTH bits
//   divisor      denominator, WIDTH bits
//   busy         high from the accepting edge until done
//   done         one-cycle pulse, quotient/remainder valid
//   quotient     result quotient (truncated toward zero)
//   remainder    result remainder (sign follows dividend in signed mode)
//   div_by_zero  set with done when divisor was 0; held until next accept
// ---------------------------------------------------------------------------
interface seq_nr_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_nr_divider.sv
// ---------------------------------------------------------------------------
// seq_nr_divider
//   Multi-cycle non-restoring integer divider, one quotient bit per clock,
//   signed or unsigned per operation, with divide-by-zero reporting.
//
//   clock  rising-edge clock
//   clear  asynchronous active-high reset; discards any in-flight divide
//   bus    seq_nr_divider_if.slave (start/is_signed/dividend/divisor in,
//          busy/done/quotient/remainder/div_by_zero out)
//
//   Latency from the accepting edge E0: done is visible after edge
//   E0+WIDTH+1 for a normal divide, after E0+1 for a zero divisor.
// ---------------------------------------------------------------------------
module seq_nr_divider #(
    parameter int WIDTH = 32
) (
    input  logic            clock,
    input  logic            clear,
    seq_nr_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_reg,  state_next;
    logic [CW-1:0]    count_reg,  count_next;
    // Dividend magnitude shifts out of the top while quotient bits shift in
    // at the bottom; after WIDTH steps this register holds the raw quotient.
    logic [WIDTH-1:0] aq_reg,     aq_next;
    logic [WIDTH-1:0] b_reg,      b_next;
    logic [WIDTH:0]   rem_reg,    rem_next;   // two's-complement partial remainder
    logic             sign_q_reg, sign_q_next;
    logic             sign_r_reg, sign_r_next;
    logic             zero_reg,   zero_next;
    logic             busy_reg,   busy_next;
    logic             done_reg,   done_next;
    logic             dbz_reg,    dbz_next;
    logic [WIDTH-1:0] quot_reg,   quot_next;
    logic [WIDTH-1:0] rmd_reg,    rmd_next;

    logic             neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   rem_shift, rem_step, rem_fix;

    // In signed mode the most negative value negates to itself, which read
    // as unsigned is exactly 2^(WIDTH-1) -- the magnitude we want.
    assign neg_a = bus.is_signed & bus.dividend[WIDTH-1];
    assign neg_b = bus.is_signed & bus.divisor[WIDTH-1];
    assign mag_a = neg_a ? -bus.dividend : bus.dividend;
    assign mag_b = neg_b ? -bus.divisor  : bus.divisor;

    // The remainder stays within [-B, B), so WIDTH+1 bits hold the final value
    // of every step even though the doubled intermediate can wrap.
    assign rem_shift = {rem_reg[WIDTH-1:0], aq_reg[WIDTH-1]};
    assign rem_step  = rem_reg[WIDTH] ? (rem_shift + {1'b0, b_reg})
                                      : (rem_shift - {1'b0, b_reg});
    assign rem_fix   = rem_reg[WIDTH] ? (rem_reg + {1'b0, b_reg}) : rem_reg;

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        aq_next     = aq_reg;
        b_next      = b_reg;
        rem_next    = rem_reg;
        sign_q_next = sign_q_reg;
        sign_r_next = sign_r_reg;
        zero_next   = zero_reg;
        busy_next   = busy_reg;
        done_next   = done_reg;
        dbz_next    = dbz_reg;
        quot_next   = quot_reg;
        rmd_next    = rmd_reg;

        unique case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    busy_next   = 1'b1;
                    done_next   = 1'b0;
                    dbz_next    = 1'b0;
                    sign_q_next = neg_a ^ neg_b;
                    sign_r_next = neg_a;
                    aq_next     = mag_a;
                    b_next      = mag_b;
                    rem_next    = '0;
                    count_next  = CW'(WIDTH - 1);
                    // A zero divisor skips the iteration and takes the single
                    // FIX slot, so its result appears one edge after accept.
                    if (bus.divisor == '0) begin
                        zero_next  = 1'b1;
                        state_next = FIX;
                    end else begin
                        zero_next  = 1'b0;
                        state_next = RUN;
                    end
                end
            end

            RUN: begin
                rem_next = rem_step;
                aq_next  = {aq_reg[WIDTH-2:0], ~rem_step[WIDTH]};
                if (count_reg == '0) begin
                    state_next = FIX;
                end else begin
                    count_next = count_reg - CW'(1);
                end
            end

            FIX: begin
                rem_next = rem_fix;
                if (zero_reg) begin
                    quot_next = '0;
                    rmd_next  = '0;
                    dbz_next  = 1'b1;
                end else begin
                    quot_next = sign_q_reg ? -aq_reg : aq_reg;
                    rmd_next  = sign_r_reg ? -rem_fix[WIDTH-1:0] : rem_fix[WIDTH-1:0];
                end
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = DONE;
            end

            DONE: begin
                // start is deliberately not sampled here: busy is already low
                // but the unit only accepts from IDLE.
                done_next  = 1'b0;
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            aq_reg     <= '0;
            b_reg      <= '0;
            rem_reg    <= '0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            zero_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            dbz_reg    <= 1'b0;
            quot_reg   <= '0;
            rmd_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            aq_reg     <= aq_next;
            b_reg      <= b_next;
            rem_reg    <= rem_next;
            sign_q_reg <= sign_q_next;
            sign_r_reg <= sign_r_next;
            zero_reg   <= zero_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            dbz_reg    <= dbz_next;
            quot_reg   <= quot_next;
            rmd_reg    <= rmd_next;
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.quotient    = quot_reg;
    assign bus.remainder   = rmd_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_nr_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_nr_divider
//   Directed WIDTH=8 cases (signs, unsigned range, zero divisor, overflow,
//   mid-run clear, ignored starts) followed by a WIDTH=32 random regression
//   on NL parallel lanes. Expected results are pushed to scoreboard queues
//   when a request is driven and popped when the matching done appears.
// ---------------------------------------------------------------------------
module tb_seq_nr_divider;
    localparam int NL      = 8;
    localparam int PER_LANE = 1250;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- WIDTH=8 unit ----------------
    seq_nr_divider_if #(.WIDTH(8)) bus8 ();
    seq_nr_divider #(.WIDTH(8)) dut8 (.clock(clock), .clear(clear), .bus(bus8));
    exp_t sb8[$];

    // ---------------- WIDTH=32 lanes ----------------
    logic        start32 [NL];
    logic        sgn32   [NL];
    logic [31:0] a32     [NL];
    logic [31:0] b32     [NL];
    logic        done32  [NL];
    logic [31:0] q32     [NL];
    logic [31:0] r32     [NL];
    logic        z32     [NL];
    exp_t        sb32    [NL][$];

    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
        seq_nr_divider_if #(.WIDTH(32)) bus32 ();
        seq_nr_divider #(.WIDTH(32)) dut32 (.clock(clock), .clear(clear), .bus(bus32));
        assign bus32.start     = start32[gi];
        assign bus32.is_signed = sgn32[gi];
        assign bus32.dividend  = a32[gi];
        assign bus32.divisor   = b32[gi];
        assign done32[gi]      = bus32.done;
        assign q32[gi]         = bus32.quotient;
        assign r32[gi]         = bus32.remainder;
        assign z32[gi]         = bus32.div_by_zero;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: divide magnitudes with the language operator, then restore signs.
    function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t        e;
        logic        na, nb;
        logic [31:0] ma, mb, uq, ur;
        e.a = a; e.b = b; e.s = s;
        if (b == 32'd0) begin
            e.q = '0; e.r = '0; e.z = 1'b1;
        end else begin
            na = s & a[31];
            nb = s & b[31];
            ma = na ? -a : a;
            mb = nb ? -b : b;
            uq = ma / mb;
            ur = ma % mb;
            e.q = (na ^ nb) ? -uq : uq;
            e.r = na ? -ur : ur;
            e.z = 1'b0;
        end
        return e;
    endfunction

    // One WIDTH=8 transaction. poke>0 pulses a different start at that cycle
    // of the run; poke_done drives start during the done cycle.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [7:0] eq, input logic [7:0] er,
                        input logic ez, input int poke, input bit poke_done);
        exp_t e;
        int   lat;
        e.a = {24'd0, a}; e.b = {24'd0, b}; e.s = s;
        e.q = {24'd0, eq}; e.r = {24'd0, er}; e.z = ez;
        sb8.push_back(e);
        @(negedge clock);
        check({tag, ".idle"}, bus8.busy, 0);
        bus8.start     = 1'b1;
        bus8.is_signed = s;
        bus8.dividend  = a;
        bus8.divisor   = b;
        @(negedge clock);
        lat = 1;
        bus8.start     = 1'b0;
        bus8.is_signed = ~s;
        bus8.dividend  = 8'($urandom);
        bus8.divisor   = 8'($urandom);
        check({tag, ".busy"}, bus8.busy, 1);
        check({tag, ".dbz_clr"}, bus8.div_by_zero, 0);
        check({tag, ".done_lo"}, bus8.done, 0);
        while (bus8.done !== 1'b1 && lat < 40) begin
            if (poke != 0 && lat == poke) begin
                bus8.start    = 1'b1;
                bus8.dividend = 8'd50;
                bus8.divisor  = 8'd3;
            end else begin
                bus8.start = 1'b0;
            end
            @(negedge clock);
            lat++;
        end
        bus8.start = 1'b0;
        e = sb8.pop_front();
        check({tag, ".latency"}, 64'(lat), e.z ? 64'd2 : 64'd10);
        check({tag, ".quotient"}, bus8.quotient, e.q);
        check({tag, ".remainder"}, bus8.remainder, e.r);
        check({tag, ".dbz"}, bus8.div_by_zero, e.z);
        check({tag, ".busy_end"}, bus8.busy, 0);
        $display("txn8 %s a=%h b=%h s=%0b q=%h r=%h dbz=%0b lat=%0d",
                 tag, a, b, s, bus8.quotient, bus8.remainder, bus8.div_by_zero, lat);
        if (poke_done) begin
            bus8.start    = 1'b1;
            bus8.dividend = 8'd9;
            bus8.divisor  = 8'd3;
        end
        @(negedge clock);
        bus8.start = 1'b0;
        check({tag, ".done_fall"}, bus8.done, 0);
        check({tag, ".no_accept"}, bus8.busy, 0);
        check({tag, ".q_hold"}, bus8.quotient, e.q);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic [31:0] a, b, lhs, mr, mb;
        logic        s;
        bit          pending [NL];
        bit          any;
        int          cyc;

        bus8.start = 1'b0; bus8.is_signed = 1'b0;
        bus8.dividend = '0; bus8.divisor = '0;
        for (int l = 0; l < NL; l++) begin
            start32[l] = 1'b0; sgn32[l] = 1'b0; a32[l] = '0; b32[l] = '0;
        end

        // Reset state
        repeat (3) @(negedge clock);
        check("rst.busy", bus8.busy, 0);
        check("rst.done", bus8.done, 0);
        check("rst.quotient", bus8.quotient, 0);
        check("rst.remainder", bus8.remainder, 0);
        check("rst.dbz", bus8.div_by_zero, 0);
        clear = 1'b0;

        // Signed sign combinations
        run8("s_7_2",   8'd7,   8'd2,   1, 8'd3,   8'd1,   0, 0, 0);
        run8("s_m7_2",  8'hF9,  8'd2,   1, 8'hFD,  8'hFF,  0, 0, 0);
        run8("s_7_m2",  8'd7,   8'hFE,  1, 8'hFD,  8'd1,   0, 0, 0);
        run8("s_m7_m2", 8'hF9,  8'hFE,  1, 8'd3,   8'hFF,  0, 0, 0);
        // Unsigned, including operands >= 2^(WIDTH-1)
        run8("u_200_7", 8'd200, 8'd7,   0, 8'd28,  8'd4,   0, 0, 0);
        run8("u_255_1", 8'd255, 8'd1,   0, 8'd255, 8'd0,   0, 0, 0);
        run8("u_5_9",   8'd5,   8'd9,   0, 8'd0,   8'd5,   0, 0, 0);
        run8("s_m56_7", 8'd200, 8'd7,   1, 8'hF8,  8'd0,   0, 0, 0);
        // Divide by zero in both modes; the following accept must clear the flag
        run8("u_dbz",   8'h55,  8'd0,   0, 8'd0,   8'd0,   1, 0, 0);
        run8("s_dbz",   8'h55,  8'd0,   1, 8'd0,   8'd0,   1, 0, 0);
        // Overflow wraps silently; MIN by a small divisor
        run8("s_min_m1", 8'h80, 8'hFF,  1, 8'h80,  8'd0,   0, 0, 0);
        run8("s_min_3",  8'h80, 8'd3,   1, 8'hD6,  8'hFE,  0, 0, 0);

        // Clear four cycles into RUN
        @(negedge clock);
        bus8.start = 1'b1; bus8.is_signed = 1'b0;
        bus8.dividend = 8'd100; bus8.divisor = 8'd9;
        @(negedge clock);
        bus8.start = 1'b0;
        repeat (4) @(negedge clock);
        clear = 1'b1;
        #1;
        check("clr.busy", bus8.busy, 0);
        check("clr.done", bus8.done, 0);
        check("clr.quotient", bus8.quotient, 0);
        check("clr.remainder", bus8.remainder, 0);
        check("clr.dbz", bus8.div_by_zero, 0);
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        run8("clr_rerun", 8'd100, 8'd9, 0, 8'd11, 8'd1, 0, 0, 0);

        // Start pulsed mid-run, then start held in the done cycle: both ignored
        run8("poke_run",  8'd100, 8'd9, 0, 8'd11, 8'd1, 0, 4, 1);
        run8("after_poke", 8'd7,  8'd2, 1, 8'd3,  8'd1, 0, 0, 0);

        // WIDTH=32 random regression across NL lanes
        for (int batch = 0; batch < PER_LANE; batch++) begin
            @(negedge clock);
            for (int l = 0; l < NL; l++) begin
                a = $urandom;
                b = $urandom;
                s = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 15))
                    0:       b = 32'd0;
                    1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
                    2, 3, 4: b = 32'($urandom_range(1, 255));
                    5:       b = b >> $urandom_range(0, 31);
                    default: ;
                endcase
                e = model32(a, b, s);
                sb32[l].push_back(e);
                start32[l] = 1'b1; sgn32[l] = s; a32[l] = a; b32[l] = b;
                pending[l] = 1'b1;
            end
            @(negedge clock);
            for (int l = 0; l < NL; l++) start32[l] = 1'b0;
            cyc = 0;
            any = 1'b1;
            while (any && cyc < 50) begin
                any = 1'b0;
                for (int l = 0; l < NL; l++) begin
                    if (pending[l] && done32[l] === 1'b1) begin
                        e = sb32[l].pop_front();
                        pending[l] = 1'b0;
                        check("r32.quotient", q32[l], e.q);
                        check("r32.remainder", r32[l], e.r);
                        check("r32.dbz", z32[l], e.z);
                        if (e.b != 32'd0) begin
                            lhs = q32[l] * e.b + r32[l];
                            mr  = (e.s && r32[l][31]) ? -r32[l] : r32[l];
                            mb  = (e.s && e.b[31])    ? -e.b    : e.b;
                            check("r32.identity", {63'd0, (lhs == e.a) && (mr < mb)}, 1);
                        end
                        $display("txn32 lane%0d a=%h b=%h s=%0b q=%h r=%h dbz=%0b",
                                 l, e.a, e.b, e.s, q32[l], r32[l], z32[l]);
                    end
                    any = any | pending[l];
                end
                if (any) begin
                    @(negedge clock);
                    cyc++;
                end
            end
            for (int l = 0; l < NL; l++) begin
                if (pending[l]) begin
                    check("r32.timeout", 0, 1);
                    void'(sb32[l].pop_front());
                    pending[l] = 1'b0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
